// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parametrised LCD HS/VS/DE timing with pixel prefetch, RGB565/888 output, colour bars and frame telemetry
// Ports: lcd_clk/sys_rst (async, active-high); init_done enables frames, pat_en selects colour bars (latched per frame);
//        pixel_data is the source pixel REQ_LAT cycles after data_req; pixel_xpos/pixel_ypos give the requested pixel;
//        lcd_hs/lcd_vs/lcd_de/lcd_rgb drive the panel; lcd_bl backlight; frame_start pulse and frame_cnt telemetry.
module lcd_timing_gen #(
    parameter int H_SYNC  = 4,
    parameter int H_BACK  = 40,
    parameter int H_DISP  = 480,
    parameter int H_FRONT = 5,
    parameter int V_SYNC  = 1,
    parameter int V_BACK  = 8,
    parameter int V_DISP  = 272,
    parameter int V_FRONT = 8,
    parameter int DATA_W  = 16,
    parameter int REQ_LAT = 1,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0
) (
    input  logic              lcd_clk,
    input  logic              sys_rst,
    input  logic              init_done,
    input  logic              pat_en,
    input  logic [DATA_W-1:0] pixel_data,
    output logic              data_req,
    output logic [10:0]       pixel_xpos,
    output logic [10:0]       pixel_ypos,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_de,
    output logic [23:0]       lcd_rgb,
    output logic              lcd_bl,
    output logic              frame_start,
    output logic [7:0]        frame_cnt
);
    localparam logic [10:0] H_LAST = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [10:0] V_LAST = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [10:0] HS_END = 11'(H_SYNC);
    localparam logic [10:0] VS_END = 11'(V_SYNC);
    localparam logic [10:0] DS     = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] DE     = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] RQ_S   = 11'(H_SYNC + H_BACK - REQ_LAT - 1);
    localparam logic [10:0] RQ_E   = 11'(H_SYNC + H_BACK + H_DISP - REQ_LAT - 1);
    localparam logic [10:0] VDS    = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] VDE    = 11'(V_SYNC + V_BACK + V_DISP);
    localparam logic [10:0] BAR_W  = 11'(H_DISP / 8);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [10:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, req_q, req_d;
    logic        bl_q, bl_d, fs_q, fs_d, pat_q, pat_d;
    logic [23:0] rgb_q, rgb_d, src_rgb, bar_rgb;
    logic [7:0]  fc_q, fc_d;
    logic        run, h_last, v_act, in_disp, req, fs;
    logic [2:0]  bar;

    if (DATA_W == 16) begin : g_565
        // MSBs replicated into the low bits so full-scale 565 maps to full-scale 888
        assign src_rgb = {pixel_data[15:11], pixel_data[15:13], pixel_data[10:5], pixel_data[10:9],
                          pixel_data[4:0], pixel_data[4:2]};
    end else begin : g_888
        assign src_rgb = pixel_data[23:0];
    end

    always_comb begin
        run     = state_q == RUN;
        h_last  = h_q == H_LAST;
        // init_done only matters at the last pixel, so a mid-frame drop never truncates a frame
        state_d = run ? ((h_last && v_q == V_LAST && !init_done) ? IDLE : RUN) : (init_done ? RUN : IDLE);
        h_d     = (run && !h_last) ? h_q + 11'd1 : 11'd0;
        v_d     = !run ? 11'd0 : h_last ? ((v_q == V_LAST) ? 11'd0 : v_q + 11'd1) : v_q;
        v_act   = v_q >= VDS && v_q < VDE;
        in_disp = run && v_act && h_q >= DS && h_q < DE;
        // requests lead the display window by REQ_LAT+1 so data lands exactly when lcd_de rises
        req     = run && v_act && h_q >= RQ_S && h_q < RQ_E;
        fs      = run && h_q == 11'd0 && v_q == 11'd0;
        bar     = 3'((h_q - DS) / BAR_W);
        bar_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
        hs_d    = (run && h_q < HS_END) ? HS_POL : ~HS_POL;
        vs_d    = (run && v_q < VS_END) ? VS_POL : ~VS_POL;
        de_d    = in_disp;
        req_d   = req;
        x_d     = req ? h_q - RQ_S : 11'd0;
        y_d     = req ? v_q - VDS : 11'd0;
        rgb_d   = in_disp ? (pat_q ? bar_rgb : src_rgb) : 24'd0;
        pat_d   = fs ? pat_en : pat_q;
        bl_d    = run;
        fs_d    = fs;
        fc_d    = run ? fc_q + {7'd0, fs_q} : 8'd0;
    end

    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            req_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            rgb_q   <= '0;
            pat_q   <= 1'b0;
            bl_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            req_q   <= req_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rgb_q   <= rgb_d;
            pat_q   <= pat_d;
            bl_q    <= bl_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    assign data_req    = req_q;
    assign pixel_xpos  = x_q;
    assign pixel_ypos  = y_q;
    assign lcd_hs      = hs_q;
    assign lcd_vs      = vs_q;
    assign lcd_de      = de_q;
    assign lcd_rgb     = rgb_q;
    assign lcd_bl      = bl_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fc_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed self-checking bench for lcd_timing_gen on a 15x7 geometry with a 2-cycle pixel source
module tb_lcd_timing_gen;
    logic        lcd_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        init_done = 1'b0;
    logic        pat_en = 1'b0;
    logic [15:0] pixel_data;
    logic        data_req, lcd_hs, lcd_vs, lcd_de, lcd_bl, frame_start;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic [23:0] lcd_rgb;
    logic [7:0]  frame_cnt;
    int          checks = 0;
    int          errors = 0;
    logic [22:0] p0 = '0;
    logic [22:0] p1 = '0;

    always #5 lcd_clk = ~lcd_clk;

    lcd_timing_gen #(
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .DATA_W(16), .REQ_LAT(2), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .lcd_clk(lcd_clk), .sys_rst(sys_rst), .init_done(init_done), .pat_en(pat_en),
        .pixel_data(pixel_data), .data_req(data_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb), .lcd_bl(lcd_bl),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    function automatic logic [15:0] pix(input int x, input int y);
        if (x == 3 && y == 1) return 16'hF81F;
        return {5'(x), 6'(y), 5'(x)};
    endfunction

    function automatic logic [23:0] exp565(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    // source with 2-cycle read latency; garbage when no request is in flight
    always @(posedge lcd_clk) begin
        p0 <= {data_req, pixel_xpos, pixel_ypos};
        p1 <= p0;
    end
    assign pixel_data = p1[22] ? pix(int'(p1[21:11]), int'(p1[10:0])) : 16'hAAAA;

    task automatic tick();
        @(negedge lcd_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({lcd_hs, lcd_vs, lcd_de, data_req, lcd_bl, frame_start} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 110000", {lcd_hs, lcd_vs, lcd_de, data_req, lcd_bl, frame_start});
        end
        checks++;
        if ({lcd_rgb, pixel_xpos, pixel_ypos, frame_cnt} !== 54'd0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {lcd_rgb, pixel_xpos, pixel_ypos, frame_cnt});
        end
        sys_rst = 1'b0;
        repeat (4) tick();
        checks++;
        if ({lcd_hs, lcd_vs, lcd_de, data_req, lcd_bl, frame_start} !== 6'b110000) begin
            errors++;
            $display("FAIL idle_hold got %b want 110000", {lcd_hs, lcd_vs, lcd_de, data_req, lcd_bl, frame_start});
        end
    endtask

    task automatic test_start();
        init_done = 1'b1;
        tick();
        checks++;
        if ({frame_start, lcd_bl} !== 2'b00) begin
            errors++;
            $display("FAIL start_t1 got fs/bl=%b want 00", {frame_start, lcd_bl});
        end
        tick();
        checks++;
        if ({frame_start, lcd_hs, lcd_bl, frame_cnt} !== {3'b101, 8'd0}) begin
            errors++;
            $display("FAIL start_t2 got fs/hs/bl=%b cnt=%0d want 101 cnt=0", {frame_start, lcd_hs, lcd_bl}, frame_cnt);
        end
    endtask

    task automatic test_line_timing();
        int n = 0;
        int hs_n = 0, vs_n = 0, req_n = 0, de_n = 0, req_first = -1, de_first = -1;
        logic [51:0] act, want;
        while (frame_start !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL lt_wait_fs got timeout want frame_start");
        end
        for (int k = 0; k < 105; k++) begin
            int  h = k % 15, v = k / 15;
            bit  va = v >= 2 && v < 6;
            bit  de = va && h >= 5 && h < 13;
            bit  rq = va && h >= 2 && h < 10;
            want = {h >= 2, v >= 1, de, rq, k == 0, 1'b1, rq ? 11'(h - 2) : 11'd0, rq ? 11'(v - 2) : 11'd0,
                    de ? exp565(pix(h - 5, v - 2)) : 24'd0};
            act = {lcd_hs, lcd_vs, lcd_de, data_req, frame_start, lcd_bl, pixel_xpos, pixel_ypos, lcd_rgb};
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL lt_cycle k=%0d got %h want %h", k, act, want);
            end
            if (k == 53) begin
                checks++;
                if (lcd_rgb !== 24'hFF00FF) begin
                    errors++;
                    $display("FAIL lt_px31 got %h want ff00ff", lcd_rgb);
                end
            end
            if (!lcd_hs) hs_n++;
            if (!lcd_vs) vs_n++;
            if (data_req) begin
                req_n++;
                if (req_first < 0) req_first = k;
            end
            if (lcd_de) begin
                de_n++;
                if (de_first < 0) de_first = k;
            end
            tick();
        end
        checks++;
        if ({hs_n, vs_n, req_n, de_n} !== {32'd14, 32'd15, 32'd32, 32'd32}) begin
            errors++;
            $display("FAIL lt_counts got hs=%0d vs=%0d req=%0d de=%0d want 14 15 32 32", hs_n, vs_n, req_n, de_n);
        end
        checks++;
        if (de_first - req_first !== 3) begin
            errors++;
            $display("FAIL lt_de_lag got %0d want 3", de_first - req_first);
        end
    endtask

    task automatic test_frame_period();
        checks++;
        if ({frame_start, frame_cnt} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL fp_first got fs=%b cnt=%0d want 1 1", frame_start, frame_cnt);
        end
        for (int f = 2; f <= 256; f++) begin
            int n = 0;
            do begin
                tick();
                n++;
            end while (frame_start !== 1'b1 && n < 200);
            checks++;
            if (n !== 105) begin
                errors++;
                $display("FAIL fp_period f=%0d got %0d want 105", f, n);
            end
            checks++;
            if (frame_cnt !== 8'(f)) begin
                errors++;
                $display("FAIL fp_cnt f=%0d got %0d want %0d", f, frame_cnt, f % 256);
            end
        end
    endtask

    task automatic test_pattern();
        repeat (30) tick();
        pat_en = 1'b1;
        repeat (20) tick();
        checks++;
        if ({lcd_de, lcd_rgb} !== {1'b1, 24'h000400}) begin
            errors++;
            $display("FAIL pat_same_frame got de=%b rgb=%h want 1 000400", lcd_de, lcd_rgb);
        end
        repeat (3) tick();
        checks++;
        if (lcd_rgb !== 24'hFF00FF) begin
            errors++;
            $display("FAIL pat_same_px31 got %h want ff00ff", lcd_rgb);
        end
        repeat (52) tick();
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL pat_fs got %b want 1", frame_start);
        end
        repeat (35) tick();
        checks++;
        if (lcd_rgb !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL pat_bar0 got %h want ffffff", lcd_rgb);
        end
        tick();
        checks++;
        if (lcd_rgb !== 24'hFFFF00) begin
            errors++;
            $display("FAIL pat_bar1 got %h want ffff00", lcd_rgb);
        end
        repeat (3) tick();
        checks++;
        if (lcd_rgb !== 24'hFF00FF) begin
            errors++;
            $display("FAIL pat_bar4 got %h want ff00ff", lcd_rgb);
        end
        repeat (3) tick();
        checks++;
        if ({lcd_de, lcd_rgb} !== {1'b1, 24'h000000}) begin
            errors++;
            $display("FAIL pat_bar7 got de=%b rgb=%h want 1 000000", lcd_de, lcd_rgb);
        end
        pat_en = 1'b0;
        repeat (38) tick();
        checks++;
        if (lcd_rgb !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL pat_hold got %h want ffffff", lcd_rgb);
        end
        repeat (61) tick();
        checks++;
        if (lcd_rgb !== 24'h080008) begin
            errors++;
            $display("FAIL pat_off got %h want 080008", lcd_rgb);
        end
    endtask

    task automatic test_stop_start();
        int n = 0;
        while (frame_start !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL ss_wait_fs got timeout want frame_start");
        end
        repeat (20) tick();
        init_done = 1'b0;
        repeat (61) tick();
        checks++;
        if ({lcd_de, lcd_bl} !== 2'b11) begin
            errors++;
            $display("FAIL ss_completes got de/bl=%b want 11", {lcd_de, lcd_bl});
        end
        repeat (23) tick();
        checks++;
        if ({lcd_de, lcd_bl} !== 2'b01) begin
            errors++;
            $display("FAIL ss_last got de/bl=%b want 01", {lcd_de, lcd_bl});
        end
        tick();
        checks++;
        if ({lcd_hs, lcd_vs, lcd_de, data_req, lcd_bl, frame_start} !== 6'b110000) begin
            errors++;
            $display("FAIL ss_idle got %b want 110000", {lcd_hs, lcd_vs, lcd_de, data_req, lcd_bl, frame_start});
        end
        repeat (5) tick();
        checks++;
        if ({lcd_hs, lcd_vs, lcd_de, data_req, lcd_bl, frame_start} !== 6'b110000) begin
            errors++;
            $display("FAIL ss_idle_hold got %b want 110000", {lcd_hs, lcd_vs, lcd_de, data_req, lcd_bl, frame_start});
        end
        init_done = 1'b1;
        tick();
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL ss_restart_t1 got %b want 0", frame_start);
        end
        tick();
        checks++;
        if ({frame_start, lcd_bl} !== 2'b11) begin
            errors++;
            $display("FAIL ss_restart_t2 got fs/bl=%b want 11", {frame_start, lcd_bl});
        end
    endtask

    task automatic test_reset_mid();
        repeat (36) tick();
        checks++;
        if ({lcd_de, data_req} !== 2'b11) begin
            errors++;
            $display("FAIL rm_pre got de/req=%b want 11", {lcd_de, data_req});
        end
        sys_rst = 1'b1;
        #1;
        checks++;
        if ({lcd_hs, lcd_vs, lcd_de, data_req, lcd_bl, frame_start} !== 6'b110000) begin
            errors++;
            $display("FAIL rm_ctrl got %b want 110000", {lcd_hs, lcd_vs, lcd_de, data_req, lcd_bl, frame_start});
        end
        checks++;
        if ({lcd_rgb, pixel_xpos, pixel_ypos, frame_cnt} !== 54'd0) begin
            errors++;
            $display("FAIL rm_data got %h want 0", {lcd_rgb, pixel_xpos, pixel_ypos, frame_cnt});
        end
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL rm_restart_t1 got %b want 0", frame_start);
        end
        tick();
        checks++;
        if ({frame_start, lcd_bl, frame_cnt} !== {2'b11, 8'd0}) begin
            errors++;
            $display("FAIL rm_restart_t2 got fs/bl=%b cnt=%0d want 11 0", {frame_start, lcd_bl}, frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_line_timing();
        test_frame_period();
        test_pattern();
        test_stop_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Parametrised LCD timing and pixel-fetch engine: the successor of the fixed-panel LCD driver path. It generates HS/VS/DE for any panel geometry, prefetches pixels from a source with configurable read latency, and expands RGB565 or passes RGB888. It adds a frame-boundary start/stop gate, a built-in colour-bar test pattern and frame telemetry. It sits between the frame-buffer read port and the LCD pad drivers, in the `lcd_clk` domain.

## Interface
- `H_SYNC`, 4: HS pulse width, pixels. `H_BACK`, 40: back porch. `H_DISP`, 480: active width (multiple of 8). `H_FRONT`, 5: front porch.
- `V_SYNC`, 1; `V_BACK`, 8; `V_DISP`, 272; `V_FRONT`, 8: vertical equivalents, in lines.
- `DATA_W`, 16: source pixel width; 16 = RGB565, 24 = RGB888.
- `REQ_LAT`, 1: cycles from a `data_req` cycle to its valid `pixel_data`, range 0..7. Requires `H_SYNC+H_BACK > REQ_LAT+1`.
- `HS_POL`, 0 / `VS_POL`, 0: active level of HS / VS.
- `lcd_clk` in 1: pixel clock, the only clock.
- `sys_rst` in 1: asynchronous, active-high reset.
- `init_done` in 1: panel/system ready; enables frame generation.
- `pat_en` in 1: 1 = output colour bars instead of `pixel_data`.
- `pixel_data` in DATA_W: source pixel, valid `REQ_LAT` cycles after the matching `data_req` cycle.
- `data_req` out 1: pixel fetch request, one pixel per cycle.
- `pixel_xpos` out 11: active column being requested.
- `pixel_ypos` out 11: active row being requested.
- `lcd_hs`, `lcd_vs`, `lcd_de` out 1 each: panel sync signals and data enable.
- `lcd_rgb` out 24: {R8,G8,B8}.
- `lcd_bl` out 1: backlight enable; high while running.
- `frame_start` out 1: one-cycle pulse at each frame's h=0,v=0.
- `frame_cnt` out 8: frames started, wraps 255→0.

## Operation
- Totals: H_TOTAL = sum of the H parameters; V_TOTAL likewise. DS = H_SYNC+H_BACK, DE = DS+H_DISP, VDS = V_SYNC+V_BACK.
- Counters `h_cnt` run 0..H_TOTAL-1 and `v_cnt` run 0..V_TOTAL-1. `v_cnt` advances when `h_cnt` wraps.
- State IDLE:
  - Counters are held at 0; all outputs stay at their reset values.
  - Go to RUN on the first cycle `init_done`=1.
- State RUN:
  - Counters advance every cycle.
  - `init_done` is sampled only at the last pixel of the frame (h=H_TOTAL-1, v=V_TOTAL-1). If 0 there, go to IDLE; otherwise start the next frame.
  - A drop of `init_done` mid-frame never truncates the frame.
- `pat_en` is latched at each frame start and held constant for the whole frame.
- All outputs are registered and reflect counter value c(t) in cycle t+1:
  - HS active iff h<H_SYNC; VS active iff v<V_SYNC.
  - `lcd_de`=1 iff DS≤h<DE and VDS≤v<VDS+V_DISP.
  - `data_req`=1 iff DS-REQ_LAT-1 ≤ h < DE-REQ_LAT-1 and v is an active row.
  - `pixel_xpos`/`pixel_ypos` give the requested pixel's column/row while `data_req`=1; otherwise both are 0.
  - `frame_start`=1 iff c=(0,0) in RUN.
- `frame_cnt` increments on each `frame_start`.
- `lcd_rgb` captures, in the cycle where the counter is in the display region:
  - When `pat_en`=0, DATA_W=16: MSB-replicated expansion {R5,R5[4:2], G6,G6[5:4], B5,B5[4:2]}.
  - When `pat_en`=0, DATA_W=24: passthrough.
  - When `pat_en`=1: eight bars of H_DISP/8 columns each, in order white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00).
  - Outside the display region, `lcd_rgb`=0.
- `lcd_bl` = 1 while in RUN.

## Timing
- Reset values:
  - `lcd_hs`=~HS_POL, `lcd_vs`=~VS_POL.
  - `lcd_de`, `data_req`, `lcd_bl`, `frame_start` = 0.
  - `lcd_rgb`, `pixel_xpos`, `pixel_ypos`, `frame_cnt` = 0.
  - State IDLE.
- Reset asserted mid-frame: all outputs return to reset values asynchronously. After release, restart from IDLE.
- Latency from `init_done` rising in cycle t:
  - RUN from cycle t+1.
  - `frame_start` high in cycle t+2.
  - First HS active in cycle t+2.
- Handshake: the pixel requested in cycle t must be valid throughout cycle t+REQ_LAT. It appears on `lcd_rgb` with `lcd_de`=1 in cycle t+REQ_LAT+1.
- Per active line: exactly H_DISP `data_req` cycles, contiguous. They are followed by H_DISP contiguous `lcd_de` cycles, lagging by REQ_LAT+1.
- The request window never crosses a line boundary.
- `frame_cnt` wrap 255→0 is silent.

## Test plan
- Use a small geometry for all scenarios: H 2/3/8/2 (total 15), V 1/1/4/1 (total 7), REQ_LAT=2, DATA_W=16, `init_done`=1.
- Line timing -> per line, HS active 2 cycles. 4 active lines per frame. `data_req` high 8 cycles with xpos 0..7. `lcd_de` first rises 3 cycles after `data_req` first rises.
- Frame period -> `frame_start` pulses every 105 cycles. `frame_cnt` reads 0,1,2,… and wraps after 256 frames. VS active 15 cycles per frame.
- Data path -> the source returns `pixel_data`=0xF81F for (x=3,y=1) with 2-cycle latency. Required: `lcd_rgb`=0xFF00FF on the 4th `lcd_de` cycle of the 2nd active line. 0x0000 → 0x000000.
- Pattern -> set `pat_en`=1 mid-frame. Required: no change in the current frame; the next frame shows 0xFFFFFF on de cycle 0 and 0x000000 on de cycle 7.
- Stop/start -> drop `init_done` mid-frame. Required: the frame completes, then outputs go idle and `lcd_bl`=0. Raise `init_done` again: `frame_start` occurs 2 cycles later.
- Reset mid-line -> assert `sys_rst` while `lcd_de`=1. Required: outputs go to reset values immediately, with HS/VS at their inactive levels.
